// File: rtl/mem_stage.sv
// mem_stage: RV32 memory stage.
// Issues loads/stores on a ready-handshaked data port, steers byte/half lanes,
// extends load data, resolves the branch redirect and registers MEM/WB outputs.
// Memory wait states stall the upstream pipeline. A timeout aborts the access
// and sets a sticky bus error.
module mem_stage #(
    parameter int TIMEOUT = 16  // stalled cycles before an access is aborted (>= 2)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  strCtrlM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic        PCBranchM,
    input  logic        branchM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] PCplusImmM,
    input  logic [4:0]  rdM,
    input  logic [31:0] r2M,
    output logic        PCSrcM,
    output logic [31:0] PCTargetM,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ALUoutW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  rdW,
    output logic        misalignW,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;     // stalled cycles already spent on the current access
    logic          r_drop;    // cycle right after an abort: no request, bubble to W

    // Request context captured while idle, replayed during WAIT
    logic          r_we;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic [2:0]    r_ctrl;
    logic          r_regwr;
    logic          r_load;
    logic [4:0]    r_rd;
    logic [31:0]   r_alu;

    logic          w_in_wait;
    logic          w_memop;
    logic          w_load;
    logic          w_regwr;
    logic          w_misalign;
    logic          w_mis_ev;
    logic          w_issue;
    logic          w_active;
    logic          w_done;
    logic          w_hold;
    logic          w_timeout;
    logic [CW-1:0] w_cnt_inc;
    logic [3:0]    w_st_strb;
    logic [31:0]   w_st_data;
    logic [2:0]    w_cur_ctrl;
    logic          w_cur_regwr;
    logic          w_cur_load;
    logic [4:0]    w_cur_rd;
    logic [31:0]   w_cur_alu;
    logic [31:0]   w_shifted;
    logic [31:0]   w_ld_data;

    // Branch redirect is pure combinational and independent of the FSM
    assign PCSrcM    = PCBranchM & branchM;
    assign PCTargetM = PCplusImmM;

    // A store wins when both memory controls are set; its load writeback is suppressed
    assign w_in_wait = (r_state == S_WAIT);
    assign w_memop   = MemWriteM | MemtoRegM;
    assign w_load    = MemtoRegM & ~MemWriteM;
    assign w_regwr   = RegWriteM & ~MemWriteM;

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; strCtrl[1:0]=11 is treated as word
    assign w_misalign = (strCtrlM[1:0] == 2'b01 && ALUoutM[0]) ||
                        (strCtrlM[1]   && ALUoutM[1:0] != 2'b00);

    assign w_issue  = ~w_in_wait & ~r_drop & w_memop & ~w_misalign;
    assign w_mis_ev = ~w_in_wait & ~r_drop & w_memop &  w_misalign;
    assign w_active = w_issue | w_in_wait;
    assign w_done   = w_active &  dmem_ready;
    assign w_hold   = w_active & ~dmem_ready;

    // The abort happens in the TIMEOUT-th stalled cycle of an access
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_timeout = w_in_wait & ~dmem_ready & (w_cnt_inc == CW'(TIMEOUT));

    // Store lane steering: replicate data across lanes, shift strobes by the byte offset
    always_comb begin
        w_st_strb = 4'b1111;
        w_st_data = r2M;
        case (strCtrlM[1:0])
            2'b00: begin
                w_st_strb = 4'b0001 << ALUoutM[1:0];
                w_st_data = {4{r2M[7:0]}};
            end
            2'b01: begin
                w_st_strb = 4'b0011 << ALUoutM[1:0];
                w_st_data = {2{r2M[15:0]}};
            end
            default: ;
        endcase
        if (!MemWriteM) w_st_strb = 4'b0000;
    end

    // During WAIT the access is described by the captured copies, not the live inputs
    assign w_cur_ctrl  = w_in_wait ? r_ctrl  : strCtrlM;
    assign w_cur_regwr = w_in_wait ? r_regwr : w_regwr;
    assign w_cur_load  = w_in_wait ? r_load  : w_load;
    assign w_cur_rd    = w_in_wait ? r_rd    : rdM;
    assign w_cur_alu   = w_in_wait ? r_alu   : ALUoutM;

    // Memory port; reset overrides request and stall combinationally
    assign dmem_req   = ~rst & w_active;
    assign stall      = ~rst & w_hold;
    assign dmem_addr  = {w_cur_alu[31:2], 2'b00};
    assign dmem_we    = w_in_wait ? r_we    : (w_issue & MemWriteM);
    assign dmem_wdata = w_in_wait ? r_wdata : w_st_data;
    assign dmem_wstrb = w_in_wait ? r_wstrb : (w_issue ? w_st_strb : 4'b0000);

    // Load extract: move the addressed lane to bit 0, then sign/zero extend
    assign w_shifted = dmem_rdata >> {w_cur_alu[1:0], 3'b000};
    always_comb begin
        w_ld_data = w_shifted;
        case (w_cur_ctrl)
            3'b000:  w_ld_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ld_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_ld_data = {16'd0, w_shifted[15:0]};
            default: w_ld_data = w_shifted;
        endcase
    end

    // Access FSM: IDLE issues, WAIT holds until ready or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue && !dmem_ready) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CW'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ready) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_drop  <= 1'b1;
                        bus_err <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Capture the request context every idle cycle so WAIT replays the issuing access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_ctrl  <= '0;
            r_regwr <= 1'b0;
            r_load  <= 1'b0;
            r_rd    <= '0;
            r_alu   <= '0;
        end else if (!w_in_wait) begin
            r_we    <= MemWriteM;
            r_wdata <= w_st_data;
            r_wstrb <= w_st_strb;
            r_ctrl  <= strCtrlM;
            r_regwr <= w_regwr;
            r_load  <= w_load;
            r_rd    <= rdM;
            r_alu   <= ALUoutM;
        end
    end

    // MEM/WB register: completed access, bubble, misalign flag or plain ALU result
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ALUoutW   <= '0;
            ReadDataW <= '0;
            rdW       <= '0;
            misalignW <= 1'b0;
        end else if (w_done) begin
            RegWriteW <= w_cur_regwr;
            MemtoRegW <= w_cur_load;
            ALUoutW   <= w_cur_alu;
            ReadDataW <= w_cur_load ? w_ld_data : 32'd0;
            rdW       <= w_cur_rd;
            misalignW <= 1'b0;
        end else if (w_hold || r_drop) begin
            // waiting or aborted: W sees a bubble
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            misalignW <= 1'b0;
        end else if (w_mis_ev) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ALUoutW   <= ALUoutM;
            ReadDataW <= '0;
            rdW       <= rdM;
            misalignW <= 1'b1;
        end else begin
            RegWriteW <= RegWriteM;
            MemtoRegW <= 1'b0;
            ALUoutW   <= ALUoutM;
            ReadDataW <= '0;
            rdW       <= rdM;
            misalignW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table for single-cycle accesses plus
// hand-written sequences for wait states, timeout and reset during WAIT.
module tb_mem_stage;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  strCtrlM;
    logic        RegWriteM, MemWriteM, MemtoRegM, PCBranchM, branchM;
    logic [31:0] ALUoutM, PCplusImmM, r2M;
    logic [4:0]  rdM;
    logic        PCSrcM;
    logic [31:0] PCTargetM;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ALUoutW, ReadDataW;
    logic [4:0]  rdW;
    logic        misalignW, bus_err;

    int n_checks = 0;
    int n_err    = 0;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .strCtrlM(strCtrlM), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCBranchM(PCBranchM),
        .branchM(branchM), .ALUoutM(ALUoutM), .PCplusImmM(PCplusImmM), .rdM(rdM),
        .r2M(r2M), .PCSrcM(PCSrcM), .PCTargetM(PCTargetM), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ALUoutW(ALUoutW), .ReadDataW(ReadDataW), .rdW(rdW), .misalignW(misalignW),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [2:0]  ctrl;
        logic        rw, mw, mr, pb, br;
        logic [31:0] alu, imm;
        logic [4:0]  rd;
        logic [31:0] r2, rdata;
        logic        rdy;
        logic        e_req, e_we;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        logic        e_stall, e_pc, e_rw, e_m2r;
        logic [31:0] e_rdw;
        logic        e_mis;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic [2:0] c, input logic rw, input logic mw, input logic mr,
                       input logic [31:0] a, input logic [4:0] d, input logic [31:0] r2v,
                       input logic [31:0] rdat, input logic rdy);
        strCtrlM = c; RegWriteM = rw; MemWriteM = mw; MemtoRegM = mr;
        PCBranchM = 1'b0; branchM = 1'b0; PCplusImmM = 32'h0;
        ALUoutM = a; rdM = d; r2M = r2v; dmem_rdata = rdat; dmem_ready = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        logic hit;

        //            name   ctrl    rw    mw    mr    pb    br    alu           imm         rd     r2            rdata         rdy   req   we    strb     wdata         stl   pc    rw    m2r   ReadDataW     mis
        tv[0]  = '{"LB",   3'b000,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0000_1003,32'h0,      5'd5, 32'h0,        32'h80FF_FF12,1'b1, 1'b1,1'b0,4'b0000,32'h0,        1'b0,1'b0,1'b1,1'b1,32'hFFFF_FF80,1'b0};
        tv[1]  = '{"LH",   3'b001,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0000_2002,32'h0,      5'd6, 32'h0,        32'h8001_7FFF,1'b1, 1'b1,1'b0,4'b0000,32'h0,        1'b0,1'b0,1'b1,1'b1,32'hFFFF_8001,1'b0};
        tv[2]  = '{"LBU",  3'b100,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0000_2001,32'h0,      5'd7, 32'h0,        32'h0000_F300,1'b1, 1'b1,1'b0,4'b0000,32'h0,        1'b0,1'b0,1'b1,1'b1,32'h0000_00F3,1'b0};
        tv[3]  = '{"LW",   3'b010,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0000_3000,32'h0,      5'd8, 32'h0,        32'hDEAD_BEEF,1'b1, 1'b1,1'b0,4'b0000,32'h0,        1'b0,1'b0,1'b1,1'b1,32'hDEAD_BEEF,1'b0};
        tv[4]  = '{"LHU",  3'b101,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0000_0000,32'h0,      5'd9, 32'h0,        32'h1234_F00D,1'b1, 1'b1,1'b0,4'b0000,32'h0,        1'b0,1'b0,1'b1,1'b1,32'h0000_F00D,1'b0};
        tv[5]  = '{"SB",   3'b000,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0000_0001,32'h0,      5'd0, 32'h1234_56AB,32'h0,        1'b1, 1'b1,1'b1,4'b0010,32'hABAB_ABAB,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0};
        tv[6]  = '{"SH",   3'b001,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0000_0002,32'h0,      5'd0, 32'h0000_CAFE,32'h0,        1'b1, 1'b1,1'b1,4'b1100,32'hCAFE_CAFE,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0};
        tv[7]  = '{"SW",   3'b010,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0000_0010,32'h0,      5'd0, 32'h1122_3344,32'h0,        1'b1, 1'b1,1'b1,4'b1111,32'h1122_3344,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0};
        tv[8]  = '{"SB3",  3'b000,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0000_0003,32'h0,      5'd0, 32'h0000_00FF,32'h0,        1'b1, 1'b1,1'b1,4'b1000,32'hFFFF_FFFF,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0};
        tv[9]  = '{"LWmis",3'b010,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0000_0006,32'h0,      5'd9, 32'h0,        32'h0,        1'b1, 1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1};
        tv[10] = '{"LHmis",3'b001,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0000_0101,32'h0,      5'd4, 32'h0,        32'h0,        1'b0, 1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1};
        tv[11] = '{"ALU",  3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_0055,32'h0,      5'd7, 32'h0,        32'h0,        1'b0, 1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0};
        tv[12] = '{"BRT",  3'b000,1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_0000,32'h0000_0040,5'd0,32'h0,        32'h0,        1'b0, 1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0};
        tv[13] = '{"BRN",  3'b000,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000,32'h0000_0080,5'd0,32'h0,        32'h0,        1'b0, 1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0};
        tv[14] = '{"SWLD", 3'b010,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0000_0020,32'h0,      5'd3, 32'hA5A5_0F0F,32'h0,        1'b1, 1'b1,1'b1,4'b1111,32'hA5A5_0F0F,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0};

        // Reset: outputs cleared and request/stall overridden even with a pending load
        rst = 1'b1;
        drv(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 5'd1, 32'h0, 32'h0, 1'b0);
        tick; tick;
        #2;
        chk("rst.req",   32'(dmem_req), 32'h0);
        chk("rst.stall", 32'(stall),    32'h0);
        chk("rst.RegWriteW", 32'(RegWriteW), 32'h0);
        chk("rst.MemtoRegW", 32'(MemtoRegW), 32'h0);
        chk("rst.ALUoutW",   ALUoutW,   32'h0);
        chk("rst.ReadDataW", ReadDataW, 32'h0);
        chk("rst.rdW",       32'(rdW),  32'h0);
        chk("rst.misalignW", 32'(misalignW), 32'h0);
        chk("rst.bus_err",   32'(bus_err),   32'h0);
        tick;
        rst = 1'b0;

        // Single-cycle vectors
        for (int i = 0; i < 15; i++) begin
            drv(tv[i].ctrl, tv[i].rw, tv[i].mw, tv[i].mr, tv[i].alu, tv[i].rd,
                tv[i].r2, tv[i].rdata, tv[i].rdy);
            PCBranchM = tv[i].pb; branchM = tv[i].br; PCplusImmM = tv[i].imm;
            #2;
            chk($sformatf("%s.req", tv[i].nm),    32'(dmem_req), 32'(tv[i].e_req));
            chk($sformatf("%s.stall", tv[i].nm),  32'(stall),    32'(tv[i].e_stall));
            chk($sformatf("%s.PCSrcM", tv[i].nm), 32'(PCSrcM),   32'(tv[i].e_pc));
            chk($sformatf("%s.PCTargetM", tv[i].nm), PCTargetM, tv[i].imm);
            chk($sformatf("%s.wstrb", tv[i].nm),  32'(dmem_wstrb), 32'(tv[i].e_strb));
            if (tv[i].e_req) begin
                chk($sformatf("%s.we", tv[i].nm),   32'(dmem_we), 32'(tv[i].e_we));
                chk($sformatf("%s.addr", tv[i].nm), dmem_addr, {tv[i].alu[31:2], 2'b00});
            end
            if (tv[i].e_we)
                chk($sformatf("%s.wdata", tv[i].nm), dmem_wdata, tv[i].e_wd);
            tick;
            chk($sformatf("%s.RegWriteW", tv[i].nm), 32'(RegWriteW), 32'(tv[i].e_rw));
            chk($sformatf("%s.MemtoRegW", tv[i].nm), 32'(MemtoRegW), 32'(tv[i].e_m2r));
            chk($sformatf("%s.misalignW", tv[i].nm), 32'(misalignW), 32'(tv[i].e_mis));
            if (!tv[i].e_mis && !tv[i].e_we)
                chk($sformatf("%s.ReadDataW", tv[i].nm), ReadDataW, tv[i].e_rdw);
            if (tv[i].e_rw) begin
                chk($sformatf("%s.rdW", tv[i].nm),     32'(rdW), 32'(tv[i].rd));
                chk($sformatf("%s.ALUoutW", tv[i].nm), ALUoutW,  tv[i].alu);
            end
        end

        // LHU with three wait cycles: stall 3 cycles, result on the 4th edge
        drv(3'b101, 1'b1, 1'b0, 1'b1, 32'h0000_2002, 5'd12, 32'h0, 32'h0, 1'b0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            #2;
            if (stall) cnt++;
            chk($sformatf("lhu.req%0d", k),  32'(dmem_req), 32'h1);
            chk($sformatf("lhu.addr%0d", k), dmem_addr, 32'h0000_2000);
            tick;
            chk($sformatf("lhu.bubble%0d", k), 32'(RegWriteW), 32'h0);
        end
        chk("lhu.stall_cycles", 32'(cnt), 32'd3);
        dmem_ready = 1'b1; dmem_rdata = 32'hBEEF_1234;
        #2;
        chk("lhu.stall_done", 32'(stall), 32'h0);
        tick;
        chk("lhu.ReadDataW", ReadDataW, 32'h0000_BEEF);
        chk("lhu.RegWriteW", 32'(RegWriteW), 32'h1);
        chk("lhu.MemtoRegW", 32'(MemtoRegW), 32'h1);
        chk("lhu.rdW",       32'(rdW), 32'd12);
        drv(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
        tick;

        // Timeout: ready never comes
        drv(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 5'd3, 32'h0, 32'h0, 1'b0);
        cnt = 0; hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (stall) cnt++;
            tick;
            if (bus_err) begin hit = 1'b1; break; end
        end
        chk("to.bus_err_set", 32'(hit), 32'h1);
        chk("to.stall_cycles", 32'(cnt), 32'(TIMEOUT));
        #2;
        chk("to.req_dropped", 32'(dmem_req), 32'h0);
        chk("to.stall_clear", 32'(stall), 32'h0);
        tick;
        chk("to.RegWriteW", 32'(RegWriteW), 32'h0);
        drv(3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0011, 5'd2, 32'h0, 32'h0, 1'b0);
        tick; tick;
        chk("to.bus_err_sticky", 32'(bus_err), 32'h1);
        chk("to.alu_after", ALUoutW, 32'h0000_0011);

        // Reset two cycles into WAIT
        drv(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 5'd6, 32'h0, 32'h0, 1'b0);
        tick; tick;
        rst = 1'b1;
        #2;
        chk("rw.req",   32'(dmem_req), 32'h0);
        chk("rw.stall", 32'(stall),    32'h0);
        tick;
        chk("rw.RegWriteW", 32'(RegWriteW), 32'h0);
        chk("rw.ALUoutW",   ALUoutW,  32'h0);
        chk("rw.rdW",       32'(rdW), 32'h0);
        chk("rw.bus_err",   32'(bus_err), 32'h0);
        rst = 1'b0;
        drv(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
        #2;
        chk("rw.idle_req",   32'(dmem_req), 32'h0);
        chk("rw.idle_stall", 32'(stall),    32'h0);
        tick;
        drv(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0084, 5'd6, 32'h0, 32'h0BAD_F00D, 1'b1);
        #2;
        chk("rw.post_stall", 32'(stall), 32'h0);
        tick;
        chk("rw.post_data", ReadDataW, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
